// File: rtl/pid_loop_scheduler.sv
// Shares one PID engine between the speed loop and the d/q current loops.
// Define PID_TIMEOUT_CHECK_EN to abort a sequence when the PID never answers.
module pid_loop_scheduler #(
  parameter int DATA_WIDTH = 16,
  parameter int SPEED_DIV  = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic                  sys_clk,
  input  logic                  reset_n,
  input  logic                  loop_enable_in,
  input  logic                  loop_trigger_in,
  input  logic                  err_clear_in,
  input  logic [DATA_WIDTH-1:0] speed_param_p_in,
  input  logic [DATA_WIDTH-1:0] speed_param_i_in,
  input  logic [DATA_WIDTH-1:0] speed_param_d_in,
  input  logic [DATA_WIDTH-1:0] cur_d_param_p_in,
  input  logic [DATA_WIDTH-1:0] cur_d_param_i_in,
  input  logic [DATA_WIDTH-1:0] cur_d_param_d_in,
  input  logic [DATA_WIDTH-1:0] cur_q_param_p_in,
  input  logic [DATA_WIDTH-1:0] cur_q_param_i_in,
  input  logic [DATA_WIDTH-1:0] cur_q_param_d_in,
  input  logic [DATA_WIDTH-1:0] speed_set_val_in,
  input  logic [DATA_WIDTH-1:0] speed_detect_val_in,
  input  logic [DATA_WIDTH-1:0] current_d_set_val_in,
  input  logic [DATA_WIDTH-1:0] current_d_detect_val_in,
  input  logic [DATA_WIDTH-1:0] current_q_detect_val_in,
  output logic                  pid_cal_enable_out,
  output logic [DATA_WIDTH-1:0] pid_param_p_out,
  output logic [DATA_WIDTH-1:0] pid_param_i_out,
  output logic [DATA_WIDTH-1:0] pid_param_d_out,
  output logic [DATA_WIDTH-1:0] pid_set_value_out,
  output logic [DATA_WIDTH-1:0] pid_detect_value_out,
  input  logic [DATA_WIDTH-1:0] pid_cal_value_in,
  input  logic                  pid_cal_done_in,
  output logic [DATA_WIDTH-1:0] current_q_set_val_out,
  output logic [DATA_WIDTH-1:0] voltage_d_out,
  output logic [DATA_WIDTH-1:0] voltage_q_out,
  output logic                  loop_cal_done_out,
  output logic                  busy_out,
  output logic                  overrun_err_out,
  output logic                  timeout_err_out
);

  localparam int CW = (SPEED_DIV > 1) ? $clog2(SPEED_DIV) : 1;
  localparam logic [CW-1:0] DIV_RLD = CW'(SPEED_DIV - 1);

  typedef enum logic [2:0] {
    IDLE, SPD_REQ, SPD_WAIT,
    ID_REQ, ID_WAIT, IQ_REQ, IQ_WAIT
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] spd_cnt;
  logic          wait_st;
  logic          done_ok;
  logic          tmo;

  assign wait_st = (state == SPD_WAIT) ||
                   (state == ID_WAIT)  ||
                   (state == IQ_WAIT);
  assign done_ok = wait_st && pid_cal_done_in && loop_enable_in;

`ifdef PID_TIMEOUT_CHECK_EN
  localparam logic [7:0] TO = 8'(TIMEOUT);
  logic [7:0] wait_cnt;

  assign tmo = wait_st && !pid_cal_done_in && (wait_cnt == TO);

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt        <= '0;
      timeout_err_out <= 1'b0;
    end else begin
      if (!wait_st)  wait_cnt <= '0;
      else if (!tmo) wait_cnt <= wait_cnt + 8'd1;
      if (tmo)               timeout_err_out <= 1'b1;
      else if (err_clear_in) timeout_err_out <= 1'b0;
    end
  end
`else
  assign tmo             = 1'b0;
  assign timeout_err_out = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:
        if (loop_trigger_in)
          state_nxt = (spd_cnt == '0) ? SPD_REQ : ID_REQ;
      SPD_REQ:  state_nxt = SPD_WAIT;
      SPD_WAIT:
        if (pid_cal_done_in) state_nxt = ID_REQ;
        else if (tmo)        state_nxt = IDLE;
      ID_REQ:   state_nxt = ID_WAIT;
      ID_WAIT:
        if (pid_cal_done_in) state_nxt = IQ_REQ;
        else if (tmo)        state_nxt = IDLE;
      IQ_REQ:   state_nxt = IQ_WAIT;
      IQ_WAIT:
        if (pid_cal_done_in || tmo) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
    // Enable low overrides everything, including a done in the same cycle
    if (!loop_enable_in) state_nxt = IDLE;
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state                 <= IDLE;
      spd_cnt               <= '0;
      pid_cal_enable_out    <= 1'b0;
      busy_out              <= 1'b0;
      loop_cal_done_out     <= 1'b0;
      overrun_err_out       <= 1'b0;
      current_q_set_val_out <= '0;
      voltage_d_out         <= '0;
      voltage_q_out         <= '0;
    end else begin
      state              <= state_nxt;
      pid_cal_enable_out <= (state_nxt == SPD_REQ) ||
                            (state_nxt == ID_REQ)  ||
                            (state_nxt == IQ_REQ);
      busy_out           <= (state_nxt != IDLE);
      loop_cal_done_out  <= done_ok && (state == IQ_WAIT);
      if (state == IDLE && state_nxt == SPD_REQ)
        spd_cnt <= DIV_RLD;
      else if (state == IDLE && state_nxt == ID_REQ)
        spd_cnt <= spd_cnt - CW'(1);
      if (done_ok) begin
        unique case (state)
          SPD_WAIT: current_q_set_val_out <= pid_cal_value_in;
          ID_WAIT:  voltage_d_out         <= pid_cal_value_in;
          IQ_WAIT:  voltage_q_out         <= pid_cal_value_in;
          default:  ;
        endcase
      end
      if (loop_trigger_in && state != IDLE) overrun_err_out <= 1'b1;
      else if (err_clear_in)                overrun_err_out <= 1'b0;
    end
  end

  // Operands are captured on entry to REQ and held through the WAIT
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      pid_param_p_out      <= '0;
      pid_param_i_out      <= '0;
      pid_param_d_out      <= '0;
      pid_set_value_out    <= '0;
      pid_detect_value_out <= '0;
    end else begin
      unique case (1'b1)
        (state_nxt == SPD_REQ): begin
          pid_param_p_out      <= speed_param_p_in;
          pid_param_i_out      <= speed_param_i_in;
          pid_param_d_out      <= speed_param_d_in;
          pid_set_value_out    <= speed_set_val_in;
          pid_detect_value_out <= speed_detect_val_in;
        end
        (state_nxt == ID_REQ): begin
          pid_param_p_out      <= cur_d_param_p_in;
          pid_param_i_out      <= cur_d_param_i_in;
          pid_param_d_out      <= cur_d_param_d_in;
          pid_set_value_out    <= current_d_set_val_in;
          pid_detect_value_out <= current_d_detect_val_in;
        end
        (state_nxt == IQ_REQ): begin
          pid_param_p_out      <= cur_q_param_p_in;
          pid_param_i_out      <= cur_q_param_i_in;
          pid_param_d_out      <= cur_q_param_d_in;
          pid_set_value_out    <= current_q_set_val_out;
          pid_detect_value_out <= current_q_detect_val_in;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pid_loop_scheduler.sv
// Bench for pid_loop_scheduler: vector table, operand/result scoreboard
// and hand sequences for overrun, abort, reset and timeout.
module tb_pid_loop_scheduler;
  localparam int DW  = 16;
  localparam int SD  = 4;
  localparam int LAT = 20;

  logic          sys_clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          loop_enable_in, loop_trigger_in, err_clear_in;
  logic [DW-1:0] speed_param_p_in, speed_param_i_in, speed_param_d_in;
  logic [DW-1:0] cur_d_param_p_in, cur_d_param_i_in, cur_d_param_d_in;
  logic [DW-1:0] cur_q_param_p_in, cur_q_param_i_in, cur_q_param_d_in;
  logic [DW-1:0] speed_set_val_in, speed_detect_val_in;
  logic [DW-1:0] current_d_set_val_in, current_d_detect_val_in;
  logic [DW-1:0] current_q_detect_val_in;
  logic          pid_cal_enable_out;
  logic [DW-1:0] pid_param_p_out, pid_param_i_out, pid_param_d_out;
  logic [DW-1:0] pid_set_value_out, pid_detect_value_out;
  logic [DW-1:0] pid_cal_value_in;
  logic          pid_cal_done_in;
  logic [DW-1:0] current_q_set_val_out, voltage_d_out, voltage_q_out;
  logic          loop_cal_done_out, busy_out;
  logic          overrun_err_out, timeout_err_out;

  always #5 sys_clk = ~sys_clk;

  pid_loop_scheduler #(
    .DATA_WIDTH(DW), .SPEED_DIV(SD), .TIMEOUT(255)
  ) dut (
    .sys_clk(sys_clk), .reset_n(reset_n),
    .loop_enable_in(loop_enable_in),
    .loop_trigger_in(loop_trigger_in),
    .err_clear_in(err_clear_in),
    .speed_param_p_in(speed_param_p_in),
    .speed_param_i_in(speed_param_i_in),
    .speed_param_d_in(speed_param_d_in),
    .cur_d_param_p_in(cur_d_param_p_in),
    .cur_d_param_i_in(cur_d_param_i_in),
    .cur_d_param_d_in(cur_d_param_d_in),
    .cur_q_param_p_in(cur_q_param_p_in),
    .cur_q_param_i_in(cur_q_param_i_in),
    .cur_q_param_d_in(cur_q_param_d_in),
    .speed_set_val_in(speed_set_val_in),
    .speed_detect_val_in(speed_detect_val_in),
    .current_d_set_val_in(current_d_set_val_in),
    .current_d_detect_val_in(current_d_detect_val_in),
    .current_q_detect_val_in(current_q_detect_val_in),
    .pid_cal_enable_out(pid_cal_enable_out),
    .pid_param_p_out(pid_param_p_out),
    .pid_param_i_out(pid_param_i_out),
    .pid_param_d_out(pid_param_d_out),
    .pid_set_value_out(pid_set_value_out),
    .pid_detect_value_out(pid_detect_value_out),
    .pid_cal_value_in(pid_cal_value_in),
    .pid_cal_done_in(pid_cal_done_in),
    .current_q_set_val_out(current_q_set_val_out),
    .voltage_d_out(voltage_d_out),
    .voltage_q_out(voltage_q_out),
    .loop_cal_done_out(loop_cal_done_out),
    .busy_out(busy_out),
    .overrun_err_out(overrun_err_out),
    .timeout_err_out(timeout_err_out)
  );

  typedef struct {
    logic [DW-1:0] ss, sdt, ds, dd, qd;
    logic          run;
    logic [DW-1:0] eq, evd, evq;
  } vec_t;
  typedef struct { logic [DW-1:0] p, i, d, s, t; } op_t;
  typedef struct { logic [DW-1:0] q, vd, vq; } res_t;

  vec_t tbl [8];
  vec_t va, vb;
  op_t  opq [$];
  res_t resq [$];
  op_t  eo;
  res_t er;
  int   n_vec = 0, n_bad = 0;
  int   en_cnt = 0, done_cnt = 0, d0 = 0;
  bit   pd = 1'b0;
  bit   pid_respond = 1'b1;
  int   pcnt = 0;
  logic [DW-1:0] pv;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic op_t mk(int l, int k, logic [DW-1:0] s, t);
    op_t o;
    o.p = 16'(32'h1100 + l * 32'h1000 + k);
    o.i = 16'(32'h1200 + l * 32'h1000 + k);
    o.d = 16'(32'h1300 + l * 32'h1000 + k);
    o.s = s;
    o.t = t;
    return o;
  endfunction

  // PID model: answers set - detect LAT cycles after each start pulse
  initial begin
    pid_cal_done_in  = 1'b0;
    pid_cal_value_in = '0;
    forever begin
      @(negedge sys_clk);
      pid_cal_done_in = 1'b0;
      if (!reset_n) pcnt = 0;
      else begin
        if (pcnt > 0) begin
          pcnt--;
          if (pcnt == 0) begin
            pid_cal_done_in  = 1'b1;
            pid_cal_value_in = pv;
          end
        end
        if (pid_cal_enable_out && pid_respond) begin
          pv   = pid_set_value_out - pid_detect_value_out;
          pcnt = LAT;
        end
      end
    end
  end

  always @(posedge sys_clk)
    pd = pid_cal_done_in && busy_out && loop_enable_in;

  always @(negedge sys_clk) begin
    if (reset_n) begin
      if (pd)
        chk("next_after_done",
            {31'd0, pid_cal_enable_out | loop_cal_done_out}, 1);
      if (pid_cal_enable_out) begin
        en_cnt++;
        if (opq.size() == 0) chk("unexpected_enable", 0, 1);
        else begin
          eo = opq.pop_front();
          chk("op_p", pid_param_p_out, eo.p);
          chk("op_i", pid_param_i_out, eo.i);
          chk("op_d", pid_param_d_out, eo.d);
          chk("op_set", pid_set_value_out, eo.s);
          chk("op_det", pid_detect_value_out, eo.t);
        end
      end
      if (loop_cal_done_out) begin
        done_cnt++;
        chk("done_busy", busy_out, 0);
        if (resq.size() == 0) chk("unexpected_done", 0, 1);
        else begin
          er = resq.pop_front();
          chk("res_qset", current_q_set_val_out, er.q);
          chk("res_vd", voltage_d_out, er.vd);
          chk("res_vq", voltage_q_out, er.vq);
        end
      end
    end
  end

  task automatic chk_zero(string nm);
    chk({nm, "_en"}, pid_cal_enable_out, 0);
    chk({nm, "_p"}, pid_param_p_out, 0);
    chk({nm, "_i"}, pid_param_i_out, 0);
    chk({nm, "_d"}, pid_param_d_out, 0);
    chk({nm, "_set"}, pid_set_value_out, 0);
    chk({nm, "_det"}, pid_detect_value_out, 0);
    chk({nm, "_qset"}, current_q_set_val_out, 0);
    chk({nm, "_vd"}, voltage_d_out, 0);
    chk({nm, "_vq"}, voltage_q_out, 0);
    chk({nm, "_done"}, loop_cal_done_out, 0);
    chk({nm, "_busy"}, busy_out, 0);
    chk({nm, "_ovr"}, overrun_err_out, 0);
    chk({nm, "_tmo"}, timeout_err_out, 0);
  endtask

  task automatic set_in(vec_t v, int k);
    op_t a;
    a = mk(0, k, v.ss, v.sdt);
    speed_param_p_in = a.p; speed_param_i_in = a.i;
    speed_param_d_in = a.d;
    a = mk(1, k, v.ds, v.dd);
    cur_d_param_p_in = a.p; cur_d_param_i_in = a.i;
    cur_d_param_d_in = a.d;
    a = mk(2, k, 0, 0);
    cur_q_param_p_in = a.p; cur_q_param_i_in = a.i;
    cur_q_param_d_in = a.d;
    speed_set_val_in        = v.ss;
    speed_detect_val_in     = v.sdt;
    current_d_set_val_in    = v.ds;
    current_d_detect_val_in = v.dd;
    current_q_detect_val_in = v.qd;
  endtask

  task automatic pulse(bit idle_chk);
    @(negedge sys_clk) loop_trigger_in = 1'b1;
    @(negedge sys_clk) loop_trigger_in = 1'b0;
    chk("busy_k1", busy_out, 1);
    if (idle_chk) chk("enable_k1", pid_cal_enable_out, 1);
  endtask

  task automatic start_seq(vec_t v, int k, bit push_res);
    set_in(v, k);
    en_cnt = 0;
    if (v.run) opq.push_back(mk(0, k, v.ss, v.sdt));
    opq.push_back(mk(1, k, v.ds, v.dd));
    opq.push_back(mk(2, k, v.eq, v.qd));
    if (push_res) resq.push_back('{v.eq, v.evd, v.evq});
    pulse(1'b1);
  endtask

  task automatic wait_en(int n, int max);
    int c = 0;
    while (en_cnt < n && c < max) begin
      @(posedge sys_clk);
      c++;
    end
    chk("enable_wait", {31'd0, en_cnt >= n}, 1);
    @(negedge sys_clk);
  endtask

  task automatic wait_done(int start, int max);
    int c = 0;
    while (done_cnt <= start && c < max) begin
      @(posedge sys_clk);
      c++;
    end
    chk("done_wait", {31'd0, done_cnt > start}, 1);
    @(negedge sys_clk);
  endtask

  task automatic run_seq(vec_t v, int k);
    int s = done_cnt;
    start_seq(v, k, 1'b1);
    wait_done(s, 300);
    chk("n_enables", en_cnt, v.run ? 3 : 2);
    repeat (20) @(negedge sys_clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{16'd1000, 16'd400, 16'd300, 16'd100, 16'd50,
               1'b1, 16'd600, 16'd200, 16'd550};
    tbl[1] = '{16'd2000, 16'd100, 16'd500, 16'd50, 16'd100,
               1'b0, 16'd600, 16'd450, 16'd500};
    tbl[2] = '{16'd1500, 16'd500, 16'd10, 16'd20, 16'd600,
               1'b0, 16'd600, 16'hFFF6, 16'd0};
    tbl[3] = '{16'd0, 16'd0, 16'd7, 16'd7, 16'd1,
               1'b0, 16'd600, 16'd0, 16'd599};
    tbl[4] = '{16'd900, 16'd1000, 16'd40, 16'd30, 16'd0,
               1'b1, 16'hFF9C, 16'd10, 16'hFF9C};
    tbl[5] = '{16'd3, 16'd2, 16'd1, 16'd0, 16'hFF9C,
               1'b0, 16'hFF9C, 16'd1, 16'd0};
    tbl[6] = '{16'd5, 16'd5, 16'h8000, 16'd1, 16'd1,
               1'b0, 16'hFF9C, 16'h7FFF, 16'hFF9B};
    tbl[7] = '{16'd100, 16'd0, 16'd0, 16'hFFFF, 16'hFF9D,
               1'b0, 16'hFF9C, 16'd1, 16'hFFFF};

    loop_enable_in  = 1'b1;
    loop_trigger_in = 1'b0;
    err_clear_in    = 1'b0;
    set_in(tbl[0], 0);
    #2 reset_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    chk_zero("rst");
    reset_n = 1'b1;
    repeat (2) @(negedge sys_clk);

    for (int k = 0; k < 8; k++) run_seq(tbl[k], k);
    chk("done_pulses", done_cnt, 8);

    // Overrun during ID_WAIT; this trigger runs the speed loop
    va = '{ss:16'd50, sdt:16'd20, ds:16'd10, dd:16'd4, qd:16'd10,
           run:1'b1, eq:16'd30, evd:16'd6, evq:16'd20};
    d0 = done_cnt;
    start_seq(va, 8, 1'b1);
    wait_en(2, 200);
    repeat (5) @(negedge sys_clk);
    chk("ovr_before", overrun_err_out, 0);
    pulse(1'b0);
    chk("ovr_set", overrun_err_out, 1);
    wait_done(d0, 300);
    chk("ovr_enables", en_cnt, 3);
    @(negedge sys_clk) err_clear_in = 1'b1;
    @(negedge sys_clk) err_clear_in = 1'b0;
    chk("ovr_clear", overrun_err_out, 0);

    // Clear and a new overrun in the same cycle: set wins
    va.run = 1'b0;
    d0 = done_cnt;
    start_seq(va, 9, 1'b1);
    wait_en(1, 200);
    repeat (3) @(negedge sys_clk);
    loop_trigger_in = 1'b1;
    err_clear_in    = 1'b1;
    @(negedge sys_clk);
    loop_trigger_in = 1'b0;
    err_clear_in    = 1'b0;
    chk("ovr_set_wins", overrun_err_out, 1);
    wait_done(d0, 300);
    @(negedge sys_clk) err_clear_in = 1'b1;
    @(negedge sys_clk) err_clear_in = 1'b0;
    chk("ovr_clear2", overrun_err_out, 0);

    // Enable dropped during IQ_WAIT
    va = '{ss:16'd0, sdt:16'd0, ds:16'd100, dd:16'd1, qd:16'd5,
           run:1'b0, eq:16'd30, evd:16'd99, evq:16'd25};
    start_seq(va, 10, 1'b0);
    wait_en(2, 200);
    repeat (5) @(negedge sys_clk);
    loop_enable_in = 1'b0;
    @(negedge sys_clk);
    chk("abort_busy", busy_out, 0);
    chk("abort_vd", voltage_d_out, 16'd99);
    chk("abort_vq", voltage_q_out, 16'd20);
    d0 = done_cnt;
    repeat (30) @(negedge sys_clk);
    chk("abort_nodone", done_cnt, d0);
    chk("abort_vq_late", voltage_q_out, 16'd20);
    @(negedge sys_clk) loop_trigger_in = 1'b1;
    @(negedge sys_clk) loop_trigger_in = 1'b0;
    chk("dis_trig_busy", busy_out, 0);
    chk("dis_trig_ovr", overrun_err_out, 0);
    loop_enable_in = 1'b1;
    repeat (2) @(negedge sys_clk);

    // spd_cnt survived the abort: one more current-only sequence
    run_seq(va, 11);

    // Reset in the middle of SPD_WAIT
    vb = '{ss:16'd7000, sdt:16'd1000, ds:16'd1, dd:16'd1, qd:16'd1,
           run:1'b1, eq:16'd6000, evd:16'd0, evq:16'd5999};
    start_seq(vb, 12, 1'b1);
    wait_en(1, 200);
    repeat (5) @(negedge sys_clk);
    reset_n = 1'b0;
    #1;
    chk_zero("midrst");
    opq.delete();
    resq.delete();
    repeat (2) @(negedge sys_clk);
    reset_n = 1'b1;
    @(negedge sys_clk);
    run_seq(tbl[0], 13);

`ifdef PID_TIMEOUT_CHECK_EN
    pid_respond = 1'b0;
    set_in(tbl[1], 14);
    en_cnt = 0;
    opq.push_back(mk(1, 14, tbl[1].ds, tbl[1].dd));
    pulse(1'b1);
    repeat (256) @(negedge sys_clk);
    chk("tmo_busy_pre", busy_out, 1);
    chk("tmo_flag_pre", timeout_err_out, 0);
    @(negedge sys_clk);
    chk("tmo_busy", busy_out, 0);
    chk("tmo_flag", timeout_err_out, 1);
    chk("tmo_vq_kept", voltage_q_out, 16'd550);
    pid_respond = 1'b1;
`else
    chk("tmo_tied", timeout_err_out, 0);
`endif

    repeat (5) @(negedge sys_clk);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end
endmodule
